// File: rtl/alimentador_instrucoes_pkg.sv
// rtl/alimentador_instrucoes_pkg.sv - shared opcodes, state encoding and defaults for the instruction feeder
package alimentador_instrucoes_pkg;

  localparam int WD_MAX_DEF     = 15;
  localparam int PROG_WORDS_DEF = 16;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_IMM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERRO  = 3'd5
  } state_t;

  function automatic logic is_mvi(input logic [15:0] word);
    return word[8:6] == OP_MVI;
  endfunction

endpackage

// File: rtl/alimentador_instrucoes_memoria_programa.sv
// rtl/alimentador_instrucoes_memoria_programa.sv - program store, synchronous write and asynchronous read
module memoria_programa #(
  parameter int PROG_WORDS = 16
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [3:0]  waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [3:0]  raddr_i,
  output logic [15:0] rdata_o
);

  // No reset on the array: contents must survive a controller reset.
  logic [15:0] mem_q [PROG_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alimentador_instrucoes.sv
// rtl/alimentador_instrucoes.sv - feeds program words to a simple processor, with done watchdog
module alimentador_instrucoes
  import alimentador_instrucoes_pkg::*;
#(
  parameter int WD_MAX     = WD_MAX_DEF,
  parameter int PROG_WORDS = PROG_WORDS_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Load,
  input  logic [3:0]  LoadAddr,
  input  logic [15:0] LoadData,
  input  logic [4:0]  ProgLen,
  input  logic        Done,
  output logic [15:0] DIN,
  output logic        Run,
  output logic [3:0]  PC,
  output logic        Halted,
  output logic        Erro,
  output logic [7:0]  InstrCount
);

  localparam int WDW = $clog2(WD_MAX + 1);

  state_t         state_q, state_d;
  logic [3:0]     pc_q, pc_d;
  logic [4:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [15:0]    din_q, din_d;
  logic           run_q, run_d;
  logic           halted_q, halted_d;
  logic           erro_q, erro_d;
  logic           mvi_q, mvi_d;

  logic           accept;
  logic           wr_en;
  logic [3:0]     rd_addr;
  logic [15:0]    mem_word;
  logic [15:0]    rd_word;
  logic [4:0]     pc_next;
  logic [WDW-1:0] wd_inc;

  memoria_programa #(.PROG_WORDS(PROG_WORDS)) u_mem (
    .clk_i   (Clock),
    .we_i    (wr_en),
    .waddr_i (LoadAddr),
    .wdata_i (LoadData),
    .raddr_i (rd_addr),
    .rdata_o (mem_word)
  );

  assign accept  = (state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_ERRO);
  assign wr_en   = accept && Load;
  // A write landing on the same edge as the fetch must be seen by that fetch.
  assign rd_word = (wr_en && (LoadAddr == rd_addr)) ? LoadData : mem_word;
  // Five bits so a mvi at address 15 overshoots the length instead of wrapping.
  assign pc_next = {1'b0, pc_q} + (mvi_q ? 5'd2 : 5'd1);
  assign wd_inc  = wd_q + WDW'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    din_d    = din_q;
    run_d    = run_q;
    halted_d = halted_q;
    erro_d   = erro_q;
    mvi_d    = mvi_q;
    rd_addr  = pc_q;

    unique case (state_q)
      ST_IDLE, ST_HALT, ST_ERRO: begin
        if (Start) begin
          len_d    = ProgLen;
          pc_d     = 4'd0;
          cnt_d    = 8'd0;
          wd_d     = '0;
          erro_d   = 1'b0;
          rd_addr  = 4'd0;
          if (ProgLen == 5'd0) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
            run_d    = 1'b0;
            din_d    = 16'd0;
          end else begin
            state_d  = ST_FETCH;
            halted_d = 1'b0;
            run_d    = 1'b1;
            din_d    = rd_word;
          end
        end
      end

      ST_FETCH: begin
        mvi_d = is_mvi(din_q);
        wd_d  = '0;
        if (is_mvi(din_q)) begin
          state_d = ST_IMM;
          rd_addr = pc_q + 4'd1;
          din_d   = rd_word;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_IMM, ST_WAIT: begin
        if (Done) begin
          pc_d  = pc_next[3:0];
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          wd_d  = '0;
          if (pc_next < len_q) begin
            state_d = ST_FETCH;
            rd_addr = pc_next[3:0];
            din_d   = rd_word;
          end else begin
            state_d  = ST_HALT;
            run_d    = 1'b0;
            din_d    = 16'd0;
            halted_d = 1'b1;
          end
        end else if (wd_inc == WDW'(WD_MAX)) begin
          state_d = ST_ERRO;
          wd_d    = wd_inc;
          run_d   = 1'b0;
          din_d   = 16'd0;
          erro_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          wd_d    = wd_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        run_d   = 1'b0;
        din_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q  <= ST_IDLE;
      pc_q     <= 4'd0;
      len_q    <= 5'd0;
      cnt_q    <= 8'd0;
      wd_q     <= '0;
      din_q    <= 16'd0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      erro_q   <= 1'b0;
      mvi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      din_q    <= din_d;
      run_q    <= run_d;
      halted_q <= halted_d;
      erro_q   <= erro_d;
      mvi_q    <= mvi_d;
    end
  end

  assign DIN        = din_q;
  assign Run        = run_q;
  assign PC         = pc_q;
  assign Halted     = halted_q;
  assign Erro       = erro_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// tb/tb_alimentador_instrucoes.sv - randomized self-checking bench with program-level reference model
module tb_alimentador_instrucoes;

  localparam int WD = 15;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Load = 1'b0;
  logic [3:0]  LoadAddr = 4'd0;
  logic [15:0] LoadData = 16'd0;
  logic [4:0]  ProgLen = 5'd0;
  logic        Done = 1'b0;
  logic [15:0] DIN;
  logic        Run;
  logic [3:0]  PC;
  logic        Halted;
  logic        Erro;
  logic [7:0]  InstrCount;

  alimentador_instrucoes #(.WD_MAX(WD), .PROG_WORDS(16)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .Load       (Load),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .ProgLen    (ProgLen),
    .Done       (Done),
    .DIN        (DIN),
    .Run        (Run),
    .PC         (PC),
    .Halted     (Halted),
    .Erro       (Erro),
    .InstrCount (InstrCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        run;
    logic [15:0] din;
    logic [3:0]  pc;
    logic        done;
  } cyc_t;

  logic [15:0] mem_m [16];
  int          dly [16];
  cyc_t        tr [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    @(negedge Clock);
    Load = 1'b1; LoadAddr = a; LoadData = d;
    @(posedge Clock); #1;
    Load = 1'b0;
    mem_m[a] = d;
  endtask

  // Runs one program: builds the expected cycle trace from the instruction
  // rules, drives Done from that trace, and compares every cycle.
  task automatic run_prog(input string name, input int len, input bit noise,
                          input bit poke, input bit rst_mid, input bit co_load,
                          input logic [3:0] co_addr, input logic [15:0] co_data);
    int pc, cnt, sec, d, rst_at;
    bit err, mvi;
    logic [15:0] w, v;
    logic [23:0] exp_f, got_f;
    if (co_load) mem_m[co_addr] = co_data;
    tr.delete();
    pc = 0; cnt = 0; err = 0; sec = -1;
    while (pc < len && !err) begin
      w = mem_m[pc];
      if (cnt == 1) sec = tr.size();
      tr.push_back({1'b1, w, 4'(pc), noise ? 1'($urandom % 2) : 1'b0});
      mvi = (w[8:6] == 3'b001);
      v = mvi ? mem_m[(pc + 1) % 16] : w;
      d = dly[cnt];
      if (d > WD) begin
        for (int k = 0; k < WD; k++) tr.push_back({1'b1, v, 4'(pc), 1'b0});
        err = 1;
      end else begin
        for (int k = 1; k <= d; k++) tr.push_back({1'b1, v, 4'(pc), k == d});
        pc += mvi ? 2 : 1;
        cnt++;
      end
    end
    rst_at = (rst_mid && sec >= 0) ? sec + 1 : -1;

    @(negedge Clock);
    Start = 1'b1; ProgLen = 5'(len);
    if (co_load) begin Load = 1'b1; LoadAddr = co_addr; LoadData = co_data; end
    @(posedge Clock); #1;
    Start = 1'b0; Load = 1'b0;

    for (int i = 0; i < tr.size(); i++) begin
      n_tests++;
      if ({Run, DIN, PC, Halted, Erro} !== {tr[i].run, tr[i].din, tr[i].pc, 2'b00}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got run=%b din=%h pc=%0d halted=%b erro=%b, want run=%b din=%h pc=%0d halted=0 erro=0",
                 name, i, Run, DIN, PC, Halted, Erro, tr[i].run, tr[i].din, tr[i].pc);
      end
      if (i == rst_at) begin
        Resetn = 1'b1;
        @(posedge Clock); #1;
        Resetn = 1'b0;
        n_tests++;
        if ({Run, DIN, PC, Halted, Erro, InstrCount} !== 31'd0) begin
          n_fail++;
          $display("FAIL %s mid-run reset: got run=%b din=%h pc=%0d halted=%b erro=%b cnt=%0d, want all zero",
                   name, Run, DIN, PC, Halted, Erro, InstrCount);
        end
        return;
      end
      Done = tr[i].done;
      if (poke) begin
        Load = 1'b1; LoadAddr = 4'($urandom); LoadData = 16'($urandom);
        Start = 1'($urandom % 2); ProgLen = 5'($urandom_range(0, 16));
      end
      @(posedge Clock); #1;
      Done = 1'b0; Load = 1'b0; Start = 1'b0;
    end

    exp_f = {1'b0, 16'd0, 4'(pc), !err, err, 1'b0};
    got_f = {Run, DIN, PC, Halted, Erro, 1'b0};
    n_tests++;
    if (got_f !== exp_f || InstrCount !== 8'(cnt)) begin
      n_fail++;
      $display("FAIL %s final: got run=%b din=%h pc=%0d halted=%b erro=%b cnt=%0d, want run=0 din=0000 pc=%0d halted=%b erro=%b cnt=%0d",
               name, Run, DIN, PC, Halted, Erro, InstrCount, 4'(pc), !err, err, cnt);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b1;
    repeat (2) @(posedge Clock);
    #1; Resetn = 1'b0;
    n_tests++;
    if ({Run, DIN, PC, Halted, Erro, InstrCount} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset: got run=%b din=%h pc=%0d halted=%b erro=%b cnt=%0d, want all zero",
               Run, DIN, PC, Halted, Erro, InstrCount);
    end
  endtask

  task automatic test_mv();
    load_word(4'd0, 16'h0001);
    dly[0] = 1;
    run_prog("mv", 1, 0, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_mvi();
    load_word(4'd0, 16'h0040);
    load_word(4'd1, 16'h0005);
    dly[0] = 1;
    run_prog("mvi", 2, 0, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_sub_wait();
    load_word(4'd0, 16'h00C8);
    dly[0] = 3;
    run_prog("sub_wait", 1, 1, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_watchdog();
    load_word(4'd0, 16'h0081);
    dly[0] = 99;
    run_prog("watchdog", 1, 0, 0, 0, 0, 4'd0, 16'd0);
    dly[0] = WD;
    run_prog("watchdog_edge", 1, 0, 0, 0, 0, 4'd0, 16'd0);
    dly[0] = 1;
    run_prog("restart_after_erro", 1, 0, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_len_zero();
    run_prog("len_zero", 0, 0, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_mvi_wrap();
    for (int a = 0; a < 15; a++) begin
      load_word(4'(a), {7'($urandom), 3'($urandom_range(2, 4)), 6'($urandom)});
      dly[a] = $urandom_range(1, 4);
    end
    load_word(4'd15, 16'h0040);
    dly[15] = 2;
    run_prog("mvi_wrap", 16, 1, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_load_start_same();
    load_word(4'd0, 16'h0001);
    dly[0] = 2;
    run_prog("load_with_start", 1, 0, 0, 0, 1, 4'd0, 16'h0098);
  endtask

  task automatic test_reset_mid();
    load_word(4'd0, 16'h0050);
    load_word(4'd1, 16'h0011);
    load_word(4'd2, 16'h0023);
    dly[0] = 1; dly[1] = 4; dly[2] = 1;
    run_prog("reset_mid", 3, 0, 0, 1, 0, 4'd0, 16'd0);
    run_prog("after_reset", 3, 0, 0, 0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < 16; a++) begin
        load_word(4'(a), {7'($urandom), 3'($urandom_range(0, 4)), 6'($urandom)});
        dly[a] = ($urandom % 14 == 0) ? 20 : $urandom_range(1, 6);
      end
      run_prog("random", $urandom_range(1, 16), 1, 1, 0, 0, 4'd0, 16'd0);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) dly[a] = 1;
    test_reset();
    for (int a = 0; a < 16; a++) load_word(4'(a), 16'd0);
    test_mv();
    test_mvi();
    test_sub_wait();
    test_watchdog();
    test_len_zero();
    test_mvi_wrap();
    test_load_start_same();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
